fb_ifu_fetch: RTL and testbench

- Instruction fetch stage of the AssemblyLine pipeline.
- Holds the PC and issues in-order requests to a pipelined instruction memory (grant/response, response latency ≥1 cycle).
- Buffers responses in a 2-entry queue and hands {pc, inst} to decode, which feeds the immediate generator.
- Supports stall from decode and redirect (branch/jump) from execute, discarding wrong-path responses.

---
 rtl/fb_ifu_fetch_pkg.sv | 28 ++
 rtl/fb_ifu_fetch_if.sv | 35 +++
 rtl/fb_fifo2.sv | 61 ++++++
 rtl/fb_ifu_fetch.sv | 125 ++++++++++++
 tb/tb_fb_ifu_fetch.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fb_ifu_fetch_pkg.sv
// Shared definitions for the AssemblyLine instruction fetch stage.
// Contents:
//   FB_32BITS     - machine word width
//   FB_RESET_PC   - default first fetch address after reset
//   FB_INST_ALIGN - log2 of the instruction size in bytes
//   FB_DEPTH      - combined credit limit (in-flight + buffered)
//   addr_t, inst_t, id_pkt_t - address, instruction and decode packet types
//   align_pc()    - forces an address onto an instruction boundary
package fb_ifu_fetch_pkg;

   localparam int          FB_32BITS     = 32;
   localparam logic [31:0] FB_RESET_PC   = 32'h0000_0000;
   localparam int          FB_INST_ALIGN = 2;
   localparam int          FB_DEPTH      = 2;

   typedef logic [FB_32BITS-1:0] addr_t;
   typedef logic [FB_32BITS-1:0] inst_t;

   typedef struct packed {
      addr_t pc;
      inst_t inst;
   } id_pkt_t;

   function automatic addr_t align_pc(input addr_t a);
      return {a[FB_32BITS-1:FB_INST_ALIGN], {FB_INST_ALIGN{1'b0}}};
   endfunction

endpackage

// File: rtl/fb_ifu_fetch_if.sv
// Bus bundle between the fetch stage and its neighbours.
// Signals:
//   imem_req/imem_addr/imem_gnt        - request channel to instruction memory
//   imem_rvalid/imem_rdata             - in-order response channel
//   redirect_valid/redirect_pc         - PC change from execute
//   id_valid/id_ready/id_pc/id_inst    - handshake to decode
// Modports:
//   master - the fetch stage
//   slave  - memory, execute and decode seen as one environment
interface fb_ifu_fetch_if;
   import fb_ifu_fetch_pkg::*;

   logic  imem_req;
   addr_t imem_addr;
   logic  imem_gnt;
   logic  imem_rvalid;
   inst_t imem_rdata;
   logic  redirect_valid;
   addr_t redirect_pc;
   logic  id_valid;
   logic  id_ready;
   addr_t id_pc;
   inst_t id_inst;

   modport master (
      output imem_req, imem_addr, id_valid, id_pc, id_inst,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_pc, id_inst,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );

endinterface

// File: rtl/fb_fifo2.sv
// Two-entry synchronous FIFO.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset (control state only)
//   push, din     - write request and data
//   pop           - read request; ignored when empty
//   flush         - empties the FIFO, overriding push and pop
//   dout          - head entry (undefined content when empty)
//   full, empty   - occupancy flags
//   count         - number of stored entries (0..2)
// A push while full is accepted only together with a pop.
module fb_fifo2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       cnt_q;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (cnt_q == 2'd0);
   assign full    = (cnt_q == 2'd2);
   assign count   = cnt_q;
   assign dout    = mem_q[rd_ptr_q];
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_ok) wr_ptr_q <= ~wr_ptr_q;
         if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fb_ifu_fetch.sv
// Instruction fetch stage of the AssemblyLine pipeline.
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - synchronous active-low reset
//   bus    - fb_ifu_fetch_if.master: memory request/response, redirect
//            from execute, {pc, inst} handshake to decode
// Holds the PC, issues in-order requests to a pipelined instruction memory,
// pairs each response with its PC and buffers up to two instructions for
// decode. A redirect discards every response still owed to the old path.
module fb_ifu_fetch
   import fb_ifu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FB_RESET_PC,
   // Only 2 is supported: the buffer and PC queue are both two entries deep.
   parameter int          DEPTH    = FB_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   fb_ifu_fetch_if.master bus
);

   addr_t      pc_q;
   logic [1:0] inflight_q;
   logic [1:0] kill_cnt_q;

   addr_t      fetch_addr;
   logic       credit_ok;
   logic       grant;

   addr_t      rsp_pc;
   logic       pcq_full;
   logic       pcq_empty;
   logic [1:0] pcq_cnt;

   id_pkt_t    obuf_din;
   id_pkt_t    obuf_head;
   logic       obuf_push;
   logic       obuf_pop;
   logic       obuf_full;
   logic       obuf_empty;
   logic [1:0] buf_cnt;
   logic       rsp_kill;

   // ---- request side ----
   assign fetch_addr = bus.redirect_valid ? align_pc(bus.redirect_pc) : pc_q;
   // Credits cover both in-flight requests and buffered instructions, so a
   // response always finds room in the output buffer.
   assign credit_ok  = ({1'b0, inflight_q} + {1'b0, buf_cnt}) < 3'(DEPTH);
   assign bus.imem_req  = rst_n & credit_ok;
   assign bus.imem_addr = fetch_addr;
   assign grant         = bus.imem_req & bus.imem_gnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         inflight_q <= 2'd0;
         kill_cnt_q <= 2'd0;
      end else begin
         if (grant)                   pc_q <= fetch_addr + 32'd4;
         else if (bus.redirect_valid) pc_q <= fetch_addr;

         case ({grant, bus.imem_rvalid})
            2'b10:   inflight_q <= inflight_q + 2'd1;
            2'b01:   inflight_q <= inflight_q - 2'd1;
            default: inflight_q <= inflight_q;
         endcase

         // Everything in flight before the redirect is wrong-path; the
         // response arriving in the redirect cycle is dropped right here.
         // A request granted in the same cycle is not yet counted.
         if (bus.redirect_valid)
            kill_cnt_q <= inflight_q - {1'b0, bus.imem_rvalid};
         else if (bus.imem_rvalid && rsp_kill)
            kill_cnt_q <= kill_cnt_q - 2'd1;
      end
   end

   // ---- response side ----
   fb_fifo2 #(.WIDTH(32)) u_pc_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (grant),
      .pop   (bus.imem_rvalid),
      .flush (1'b0),
      .din   (fetch_addr),
      .dout  (rsp_pc),
      .full  (pcq_full),
      .empty (pcq_empty),
      .count (pcq_cnt)
   );

   assign rsp_kill  = (kill_cnt_q != 2'd0);
   assign obuf_push = bus.imem_rvalid & ~bus.redirect_valid & ~rsp_kill;
   assign obuf_din  = '{pc: rsp_pc, inst: bus.imem_rdata};

   fb_fifo2 #(.WIDTH(64)) u_out_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (obuf_push),
      .pop   (obuf_pop),
      .flush (bus.redirect_valid),
      .din   (obuf_din),
      .dout  (obuf_head),
      .full  (obuf_full),
      .empty (obuf_empty),
      .count (buf_cnt)
   );

   // ---- decode handshake ----
   // A redirect hides the head so a wrong-path instruction never transfers.
   assign bus.id_valid = ~obuf_empty & ~bus.redirect_valid;
   assign obuf_pop     = bus.id_valid & bus.id_ready;
   assign bus.id_pc    = obuf_empty ? '0 : obuf_head.pc;
   assign bus.id_inst  = obuf_empty ? '0 : obuf_head.inst;

   pcq_tracks_inflight: assert property (@(posedge clk) disable iff (!rst_n)
      pcq_cnt == inflight_q);
   rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.imem_rvalid && pcq_empty));
   pcq_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(grant && pcq_full && !bus.imem_rvalid));
   obuf_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(obuf_push && obuf_full && !obuf_pop));

endmodule

// File: tb/tb_fb_ifu_fetch.sv
// Directed bench for fb_ifu_fetch. Instruction memory answers every granted
// request after a selectable latency of 1 or 2 cycles with inst = addr + 0x1000_0000.
module tb_fb_ifu_fetch;
   import fb_ifu_fetch_pkg::*;

   logic clk;
   logic rst_n;
   int   lat;
   int   checks;
   int   errors;

   logic  s1_v, s2_v;
   addr_t s1_a, s2_a;

   fb_ifu_fetch_if bus ();

   fb_ifu_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pipelined memory: shares the fetch-stage reset.
   always @(posedge clk) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         s1_a <= '0;
         s2_a <= '0;
      end else begin
         s1_v <= bus.imem_req & bus.imem_gnt;
         s1_a <= bus.imem_addr;
         s2_v <= s1_v;
         s2_a <= s1_a;
      end
   end

   assign bus.imem_rvalid = (lat == 1) ? s1_v : s2_v;
   assign bus.imem_rdata  = ((lat == 1) ? s1_a : s2_a) + 32'h1000_0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      lat    = 1;
      rst_n  = 1'b0;
      bus.imem_gnt       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b0;

      // Reset state
      nxt(); nxt(); #1;
      chk("rst_req",      32'(bus.imem_req), 0);
      chk("rst_id_valid", 32'(bus.id_valid), 0);
      chk("rst_id_pc",    bus.id_pc, 0);
      chk("rst_id_inst",  bus.id_inst, 0);
      chk("rst_addr",     bus.imem_addr, 32'h0);
      chk("rst_inflight", 32'(dut.inflight_q), 0);
      chk("rst_kill",     32'(dut.kill_cnt_q), 0);

      // Streaming with 1-cycle memory
      rst_n = 1'b1; bus.imem_gnt = 1'b1; bus.id_ready = 1'b1; #1;
      chk("s0_req",  32'(bus.imem_req), 1);
      chk("s0_addr", bus.imem_addr, 32'h0);
      nxt(); #1;
      chk("s1_addr",     bus.imem_addr, 32'h4);
      chk("s1_req",      32'(bus.imem_req), 1);
      chk("s1_id_valid", 32'(bus.id_valid), 0);
      nxt(); #1;
      chk("s2_id_valid", 32'(bus.id_valid), 1);
      chk("s2_id_pc",    bus.id_pc, 32'h0);
      chk("s2_id_inst",  bus.id_inst, 32'h1000_0000);
      chk("s2_req",      32'(bus.imem_req), 0);
      nxt(); #1;
      chk("s3_id_pc",   bus.id_pc, 32'h4);
      chk("s3_id_inst", bus.id_inst, 32'h1000_0004);
      chk("s3_addr",    bus.imem_addr, 32'h8);
      chk("s3_req",     32'(bus.imem_req), 1);
      nxt(); #1;
      chk("s4_id_valid", 32'(bus.id_valid), 0);
      chk("s4_addr",     bus.imem_addr, 32'hC);
      nxt(); #1;
      chk("s5_id_pc", bus.id_pc, 32'h8);

      // Stall for 5 cycles
      nxt(); bus.id_ready = 1'b0; #1;
      chk("st0_id_pc", bus.id_pc, 32'hC);
      chk("st0_req",   32'(bus.imem_req), 1);
      chk("st0_addr",  bus.imem_addr, 32'h10);
      nxt(); #1;
      chk("st1_id_pc", bus.id_pc, 32'hC);
      chk("st1_req",   32'(bus.imem_req), 0);
      nxt(); #1;
      chk("st2_buf_cnt", 32'(dut.buf_cnt), 2);
      chk("st2_req",     32'(bus.imem_req), 0);
      chk("st2_id_pc",   bus.id_pc, 32'hC);
      nxt(); #1;
      chk("st3_id_pc", bus.id_pc, 32'hC);
      nxt(); #1;
      chk("st4_id_pc", bus.id_pc, 32'hC);
      chk("st4_req",   32'(bus.imem_req), 0);
      nxt(); bus.id_ready = 1'b1; #1;
      chk("rl0_id_valid", 32'(bus.id_valid), 1);
      chk("rl0_id_pc",    bus.id_pc, 32'hC);
      nxt(); #1;
      chk("rl1_id_pc", bus.id_pc, 32'h10);
      chk("rl1_req",   32'(bus.imem_req), 1);
      chk("rl1_addr",  bus.imem_addr, 32'h14);
      nxt(); #1;
      chk("rl2_id_valid", 32'(bus.id_valid), 0);
      nxt(); bus.imem_gnt = 1'b0; #1;
      chk("rl3_id_pc",   bus.id_pc, 32'h14);
      chk("rl3_id_inst", bus.id_inst, 32'h1000_0014);

      // Drain, then switch to 2-cycle memory
      nxt(); nxt(); nxt();
      lat = 2; bus.imem_gnt = 1'b1; #1;
      chk("r0_req",  32'(bus.imem_req), 1);
      chk("r0_addr", bus.imem_addr, 32'h1C);
      nxt(); #1;
      chk("r1_addr",     bus.imem_addr, 32'h20);
      chk("r1_id_valid", 32'(bus.id_valid), 0);

      // Redirect to 0x100 with two requests in flight
      nxt(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; #1;
      chk("rd_inflight", 32'(dut.inflight_q), 2);
      chk("rd_id_valid", 32'(bus.id_valid), 0);
      chk("rd_addr",     bus.imem_addr, 32'h100);
      chk("rd_req",      32'(bus.imem_req), 0);
      nxt(); bus.redirect_valid = 1'b0; #1;
      chk("rd1_kill", 32'(dut.kill_cnt_q), 1);
      chk("rd1_addr", bus.imem_addr, 32'h100);
      chk("rd1_req",  32'(bus.imem_req), 1);
      nxt(); #1;
      chk("rd2_kill",     32'(dut.kill_cnt_q), 0);
      chk("rd2_addr",     bus.imem_addr, 32'h104);
      chk("rd2_id_valid", 32'(bus.id_valid), 0);
      nxt(); #1;
      chk("rd3_id_valid", 32'(bus.id_valid), 0);
      nxt(); #1;
      chk("rd4_id_valid", 32'(bus.id_valid), 1);
      chk("rd4_id_pc",    bus.id_pc, 32'h100);
      chk("rd4_id_inst",  bus.id_inst, 32'h1000_0100);

      // Unaligned redirect target 0x203
      nxt(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203; #1;
      chk("ua_id_pc",    bus.id_pc, 32'h104);
      chk("ua_id_valid", 32'(bus.id_valid), 0);
      chk("ua_addr",     bus.imem_addr, 32'h200);
      nxt(); bus.redirect_valid = 1'b0; bus.imem_gnt = 1'b0; #1;
      chk("ua1_addr",    bus.imem_addr, 32'h204);
      chk("ua1_buf_cnt", 32'(dut.buf_cnt), 0);
      nxt(); nxt(); #1;
      chk("ua3_id_pc",   bus.id_pc, 32'h200);
      chk("ua3_id_inst", bus.id_inst, 32'h1000_0200);

      // Redirect to the top word, fetch wraps to zero
      nxt(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; bus.imem_gnt = 1'b1; #1;
      chk("wr0_addr", bus.imem_addr, 32'hFFFF_FFFC);
      chk("wr0_req",  32'(bus.imem_req), 1);
      nxt(); bus.redirect_valid = 1'b0; #1;
      chk("wr1_addr", bus.imem_addr, 32'h0);
      nxt(); #1;
      chk("wr2_req", 32'(bus.imem_req), 0);
      nxt(); bus.id_ready = 1'b0; #1;
      chk("wr3_id_pc",   bus.id_pc, 32'hFFFF_FFFC);
      chk("wr3_id_inst", bus.id_inst, 32'h0FFF_FFFC);

      // Reset mid-stream with a full buffer
      nxt(); rst_n = 1'b0; #1;
      chk("mr0_buf_cnt", 32'(dut.buf_cnt), 2);
      chk("mr0_id_pc",   bus.id_pc, 32'hFFFF_FFFC);
      nxt(); #1;
      chk("mr1_id_valid", 32'(bus.id_valid), 0);
      chk("mr1_req",      32'(bus.imem_req), 0);
      chk("mr1_id_pc",    bus.id_pc, 0);
      chk("mr1_id_inst",  bus.id_inst, 0);
      chk("mr1_inflight", 32'(dut.inflight_q), 0);
      chk("mr1_kill",     32'(dut.kill_cnt_q), 0);
      chk("mr1_buf_cnt",  32'(dut.buf_cnt), 0);
      rst_n = 1'b1; bus.id_ready = 1'b1; #1;
      chk("mr2_req",  32'(bus.imem_req), 1);
      chk("mr2_addr", bus.imem_addr, 32'h0);
      nxt(); #1;
      chk("mr3_addr",     bus.imem_addr, 32'h4);
      chk("mr3_id_valid", 32'(bus.id_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
